pipelined_alu: RTL and testbench
================================

# pipelined_alu

Parametrised, registered successor to the 64-bit combinational datapath ALU, wrapped in a valid/ready handshake. It executes the existing AND/OR/XOR/ADD/SUB encodings plus shifts, set-less-than and an iterative multiply. Results come with zero/carry/overflow/illegal flags. It sits between operand read and writeback in the sequential core, so the execute stage can stall on a multi-cycle op or on writeback back-pressure.

## Interface
- XLEN, 64, operand/result width; legal values 8, 16, 32, 64.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridden.
- One clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op present.
- in_ready  out  1  block can accept this cycle.
- a  in  XLEN  operand A.
- b  in  XLEN  operand B; shift amount is b[SHW-1:0].
- alu_control_signal  in  4  operation code.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- alu_result  out  XLEN  registered result.
- flag_zero  out  1  alu_result == 0.
- flag_carry  out  1  adder carry-out for ADD/SUB; 0 otherwise.
- flag_ovf  out  1  signed overflow for ADD/SUB; 0 otherwise.
- flag_illegal  out  1  undefined opcode was issued.

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0100 XOR, 0011 SLL, 0101 SRL, 0111 SRA, 1000 SLT (signed), 1001 SLTU, 1010 MUL (low XLEN bits of the product).
- All other opcodes are illegal: result is 0, flag_illegal = 1, and they take the single-cycle path.
- SUB is computed as a + ~b + 1. flag_carry is the raw carry-out, so SUB carry = 1 means there was no borrow.
- flag_ovf = (a[XLEN-1] == b'[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]), where b' is the inverted b for SUB.
- Shifts use the full SHW bits, so XLEN-1 is the maximum shift. SRA fills with a[XLEN-1].
- SLT/SLTU produce {XLEN-1 zeros, lt}.
- MUL is shift-add over XLEN iterations:
  - Operands are latched on accept.
  - Each cycle: if multiplier bit 0 is set, add the multiplicand into the accumulator; shift the multiplicand left and the multiplier right.
  - The result is the low XLEN bits, so signed and unsigned low products are identical.
- FSM states: IDLE, MUL, DONE.
  - IDLE + accept of a single-cycle op → DONE; result and flags are registered on the accept edge.
  - IDLE + accept of MUL → MUL; iteration counter loads XLEN-1.
  - MUL: counter decrements each cycle. On the cycle with counter == 0, the final accumulate is registered → DONE.
  - DONE: out_valid = 1. If out_ready = 0, stay in DONE with outputs frozen.
  - DONE + out_ready without a new accept → IDLE.
  - DONE + out_ready with a new accept → next op's target state. This allows back-to-back operation.
- in_ready = (state == IDLE) || (state == DONE && out_ready). It is combinational from state and out_ready only, never from in_valid.
- Accept = in_valid && in_ready. Inputs are ignored when there is no accept. a, b and the opcode need not be held after accept.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, alu_result 0, all flags 0, counter 0, MUL accumulators 0.
- Asserting rst_n low mid-MUL or in DONE aborts immediately. The pending result is discarded and never presented.
- Single-cycle op latency: accept at edge N → out_valid high after edge N (one cycle).
- MUL latency: accept at edge N → out_valid high after edge N+XLEN.
- Result/flag stability: alu_result and flags change only on an accept edge or a MUL-completion edge. They stay stable while out_valid && !out_ready.
- Throughput:
  - Single-cycle ops: one result per cycle with out_ready held high.
  - MUL: one per XLEN+1 cycles.
- Simultaneous accept in DONE + out_ready: the old result is consumed and the new op is captured on the same edge; out_valid stays 1 for a single-cycle op.
- Single-cycle ops read a and b only in the accept cycle.
- out_valid must be 0 throughout MUL state.

## Test plan
- Reset/idle: hold rst_n low, then release with no in_valid → in_ready=1, out_valid=0, alu_result=0, all flags 0 for 10 cycles.
- Add/sub flags (XLEN=64):
  - ADD 0x7FFF_FFFF_FFFF_FFFF + 1 → 0x8000_0000_0000_0000, ovf=1, carry=0, one-cycle latency.
  - SUB 5 − 5 → 0, zero=1, carry=1.
- Shifts/compare (XLEN=64):
  - SRA 0x8000_0000_0000_0000 by 63 → all ones.
  - SLL 1 by 40 → 0x100_0000_0000.
  - SLT −1 vs 1 → 1; SLTU −1 vs 1 → 0.
- MUL (XLEN=32): 0x0001_0003 × 0x0000_0010 → 0x0010_0030, out_valid exactly 32 cycles after accept; in_ready=0 throughout.
- Back-pressure/back-to-back: issue ADD 1+2, hold out_ready=0 for 5 cycles → result 3 held with in_ready=0. Then raise out_ready with XOR 0xF0^0xFF pending → next cycle result 0x0F, no bubble.
- Abort/illegal:
  - Assert rst_n low 10 cycles into a MUL → out_valid never rises for it; the next ADD 2+2 returns 4.
  - Opcode 1111 → result 0, flag_illegal=1.

Source files
------------

// File: rtl/pipelined_alu.sv
// Registered XLEN-bit ALU behind a valid/ready handshake.
// Single-cycle ops finish in one cycle; MUL is an XLEN-step shift-add.
module pipelined_alu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_control_signal,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            flag_zero,
  output logic            flag_carry,
  output logic            flag_ovf,
  output logic            flag_illegal
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state;
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] mcand, mplier, acc, acc_nx;

  logic            accept, is_sub, ill_c, carry_c, ovf_c;
  logic [XLEN-1:0] b_eff, res_c;
  logic [XLEN:0]   sum;
  logic [SHW-1:0]  shamt;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // SUB reuses the adder as a + ~b + 1, so carry=1 means no borrow.
  always_comb begin
    is_sub  = (alu_control_signal == OP_SUB);
    b_eff   = is_sub ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};
    shamt   = b[SHW-1:0];
    res_c   = '0;
    ill_c   = 1'b0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (alu_control_signal)
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_XOR:  res_c = a ^ b;
      OP_ADD, OP_SUB: begin
        res_c   = sum[XLEN-1:0];
        carry_c = sum[XLEN];
        ovf_c   = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      OP_SLL:  res_c = a << shamt;
      OP_SRL:  res_c = a >> shamt;
      OP_SRA:  res_c = $unsigned($signed(a) >>> shamt);
      OP_SLT:  res_c = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res_c = {{(XLEN-1){1'b0}}, (a < b)};
      OP_MUL:  res_c = '0;
      default: ill_c = 1'b1;
    endcase
  end

  assign acc_nx = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      alu_result   <= '0;
      flag_zero    <= 1'b0;
      flag_carry   <= 1'b0;
      flag_ovf     <= 1'b0;
      flag_illegal <= 1'b0;
    end else begin
      case (state)
        MUL: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            state        <= DONE;
            alu_result   <= acc_nx;
            flag_zero    <= (acc_nx == '0);
            flag_carry   <= 1'b0;
            flag_ovf     <= 1'b0;
            flag_illegal <= 1'b0;
          end
        end
        default: begin
          // DONE without out_ready leaves in_ready low: hold everything.
          if (in_ready) begin
            if (!accept) begin
              state <= IDLE;
            end else if (alu_control_signal == OP_MUL) begin
              state  <= MUL;
              cnt    <= SHW'(XLEN - 1);
              mcand  <= a;
              mplier <= b;
              acc    <= '0;
            end else begin
              state        <= DONE;
              alu_result   <= res_c;
              flag_zero    <= (res_c == '0);
              flag_carry   <= carry_c;
              flag_ovf     <= ovf_c;
              flag_illegal <= ill_c;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pipelined_alu.sv
// Directed bench: 64-bit instance for single-cycle ops, back-pressure and abort;
// 32-bit instance for multiply latency.
module tb_pipelined_alu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        iv = 1'b0, ir, ov, ordy = 1'b1, fz, fc, fo, fi;
  logic [63:0] a = '0, b = '0, res;
  logic [3:0]  op = '0;

  logic        iv_m = 1'b0, ir_m, ov_m, ordy_m = 1'b1, fz_m, fc_m, fo_m, fi_m;
  logic [31:0] a_m = '0, b_m = '0, res_m;
  logic [3:0]  op_m = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_alu #(.XLEN(64)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
    .alu_control_signal(op), .out_valid(ov), .out_ready(ordy), .alu_result(res),
    .flag_zero(fz), .flag_carry(fc), .flag_ovf(fo), .flag_illegal(fi)
  );

  pipelined_alu #(.XLEN(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_m), .in_ready(ir_m), .a(a_m), .b(b_m),
    .alu_control_signal(op_m), .out_valid(ov_m), .out_ready(ordy_m), .alu_result(res_m),
    .flag_zero(fz_m), .flag_carry(fc_m), .flag_ovf(fo_m), .flag_illegal(fi_m)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [3:0]  fl;   // {zero, carry, ovf, illegal}
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mul32(input string nm, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp);
    int lat;
    logic rdy_bad;
    @(negedge clk);
    chk({nm, "_in_ready"}, 64'(ir_m), 64'd1);
    iv_m = 1'b1; op_m = 4'b1010; a_m = x; b_m = y;
    @(negedge clk);
    iv_m = 1'b0; a_m = '1; b_m = '1;
    lat = 0;
    rdy_bad = 1'b0;
    while (!ov_m && lat < 40) begin
      if (ir_m) rdy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd32);
    chk({nm, "_busy_ready"}, 64'(rdy_bad), 64'd0);
    chk({nm, "_result"}, 64'(res_m), 64'(exp));
    chk({nm, "_flags"}, 64'({fz_m, fc_m, fo_m, fi_m}), 64'({(exp == 32'd0), 3'b000}));
  endtask

  initial begin
    int bad;

    vt[0]  = '{"add_ovf",   4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 4'b0010};
    vt[1]  = '{"sub_zero",  4'b0110, 64'h5, 64'h5, 64'h0, 4'b1100};
    vt[2]  = '{"sra_63",    4'b0111, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000};
    vt[3]  = '{"sll_40",    4'b0011, 64'h1, 64'd40, 64'h0000_0100_0000_0000, 4'b0000};
    vt[4]  = '{"slt",       4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1, 4'b0000};
    vt[5]  = '{"sltu",      4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b1000};
    vt[6]  = '{"ill_1111",  4'b1111, 64'h5, 64'h3, 64'h0, 4'b1001};
    vt[7]  = '{"and",       4'b0000, 64'hF0, 64'h3C, 64'h30, 4'b0000};
    vt[8]  = '{"or",        4'b0001, 64'hF0, 64'h0F, 64'hFF, 4'b0000};
    vt[9]  = '{"xor",       4'b0100, 64'hFF, 64'hF0, 64'h0F, 4'b0000};
    vt[10] = '{"sub_borrow",4'b0110, 64'h3, 64'h5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0000};
    vt[11] = '{"srl_63",    4'b0101, 64'h8000_0000_0000_0000, 64'd63, 64'h1, 4'b0000};
    vt[12] = '{"add_wrap",  4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b1100};
    vt[13] = '{"sub_ovf",   4'b0110, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0110};
    vt[14] = '{"sll_trunc", 4'b0011, 64'h1, 64'd68, 64'h10, 4'b0000};
    vt[15] = '{"ill_1100",  4'b1100, 64'h7, 64'h7, 64'h0, 4'b1001};

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ctrl", 64'({ir, ov, fz, fc, fo, fi}), 64'b100000);
      chk("idle_res", res, 64'h0);
    end

    // Single-cycle vector table
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk({vt[i].name, "_in_ready"}, 64'(ir), 64'd1);
      iv = 1'b1; op = vt[i].op; a = vt[i].a; b = vt[i].b;
      @(negedge clk);
      iv = 1'b0; a = '1; b = '1; op = 4'b0000;
      chk({vt[i].name, "_valid"}, 64'(ov), 64'd1);
      chk({vt[i].name, "_result"}, res, vt[i].res);
      chk({vt[i].name, "_flags"}, 64'({fz, fc, fo, fi}), 64'(vt[i].fl));
    end

    // Back-pressure then back-to-back accept
    @(negedge clk);
    ordy = 1'b0;
    iv = 1'b1; op = 4'b0010; a = 64'd1; b = 64'd2;
    @(negedge clk);
    op = 4'b0100; a = 64'hF0; b = 64'hFF;
    for (int k = 0; k < 5; k++) begin
      chk("hold_ctrl", 64'({ov, ir}), 64'b10);
      chk("hold_result", res, 64'd3);
      @(negedge clk);
    end
    ordy = 1'b1;
    #1;
    chk("release_in_ready", 64'(ir), 64'd1);
    @(negedge clk);
    iv = 1'b0;
    chk("b2b_valid", 64'(ov), 64'd1);
    chk("b2b_result", res, 64'h0F);
    @(negedge clk);
    chk("drain_valid", 64'(ov), 64'd0);

    // Multiply latency and results on the 32-bit instance
    mul32("mul_basic", 32'h0001_0003, 32'h0000_0010, 32'h0010_0030);
    mul32("mul_signed", 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1);
    mul32("mul_zero", 32'h1234_5678, 32'h0, 32'h0);

    // Abort a multiply with reset
    @(negedge clk);
    iv = 1'b1; op = 4'b1010; a = 64'd3; b = 64'd5;
    @(negedge clk);
    iv = 1'b0;
    bad = 0;
    repeat (10) begin
      if (ov || ir) bad++;
      @(negedge clk);
    end
    chk("mul_busy", 64'(bad), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", 64'({ir, ov}), 64'b10);
    chk("abort_res", res, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (70) begin
      @(negedge clk);
      if (ov) bad++;
    end
    chk("abort_no_valid", 64'(bad), 64'd0);
    iv = 1'b1; op = 4'b0010; a = 64'd2; b = 64'd2;
    @(negedge clk);
    iv = 1'b0;
    chk("post_abort_valid", 64'(ov), 64'd1);
    chk("post_abort_result", res, 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
